// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access using round-robin arbitration, one access at a time.
// Latency: a request sampled in IDLE at edge N gets rvalid in cycle N+MEM_LAT+1; at most one access per MEM_LAT+2 cycles.
// Backpressure: each requester holds req and its inputs until rvalid; gnt only pulses in IDLE.
package mem_port_arbiter_pkg;
    typedef enum logic [2:0] {
        ENONE  = 3'd0,
        EALIGN = 3'd1,
        EBUS   = 3'd2,
        EPERM  = 3'd3
    } errno_e;

    typedef enum logic [2:0] {
        DT_B  = 3'd0,
        DT_H  = 3'd1,
        DT_W  = 3'd2,
        DT_BU = 3'd3,
        DT_HU = 3'd4
    } mem_dt_e;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output errno_e      i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wd,
    input  mem_dt_e     d_dt,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output errno_e      d_err,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wd,
    output mem_dt_e     m_dt,
    input  logic [31:0] m_rd,
    input  errno_e      m_err
);
    localparam int   CW    = $clog2(MEM_LAT + 1);
    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_e;

    state_e        state, state_nxt;
    logic          sel, last, pick, any_req;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    assign any_req  = i_req | d_req;
    // On a tie the requester that did not win last time goes next.
    assign pick     = i_req ? (d_req ? ~last : FETCH) : DATA;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wd      = '0;
        m_dt      = DT_W;
        case (state)
            IDLE: begin
                if (any_req) begin
                    i_gnt     = (pick == FETCH);
                    d_gnt     = (pick == DATA);
                    state_nxt = ACC;
                end
            end
            ACC: begin
                m_en = 1'b1;
                if (sel == DATA) begin
                    m_addr = d_addr;
                    m_dt   = d_dt;
                    m_wd   = d_wd;
                    // Strobe only in the last access cycle so a store commits once.
                    m_we   = d_we & cnt_zero;
                end else begin
                    m_addr = i_addr;
                end
                if (cnt_zero) state_nxt = RESP;
            end
            RESP: begin
                i_rvalid  = (sel == FETCH);
                d_rvalid  = (sel == DATA);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel     <= FETCH;
            last    <= DATA;
            cnt     <= '0;
            i_rdata <= '0;
            i_err   <= ENONE;
            d_rdata <= '0;
            d_err   <= ENONE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel  <= pick;
                        last <= pick;
                        cnt  <= CW'(MEM_LAT - 1);
                    end
                end
                ACC: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CW'(1);
                    end else if (sel == DATA) begin
                        // Stores report status only; load data stays as it was.
                        if (!d_we) d_rdata <= m_rd;
                        d_err <= m_err;
                    end else begin
                        i_rdata <= m_rd;
                        i_err   <= m_err;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: u1 runs MEM_LAT=1, u3 runs MEM_LAT=3, both see the same requests.
// The memory model answers whichever instance use3 selects.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wd = '0;
    mem_dt_e     d_dt = DT_W;
    errno_e      m_err = ENONE;
    logic [31:0] m_rd;
    logic        use3 = 1'b0;
    logic [31:0] mem [16];

    logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wd1;
    errno_e      i_err1, d_err1;
    mem_dt_e     m_dt1;
    logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3;
    logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wd3;
    errno_e      i_err3, d_err3;
    mem_dt_e     m_dt3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign m_rd = mem[use3 ? m_addr3[5:2] : m_addr1[5:2]];

    mem_port_arbiter #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1),
        .i_rdata(i_rdata1), .i_err(i_err1),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wd(d_wd), .d_dt(d_dt),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
        .m_en(m_en1), .m_addr(m_addr1), .m_we(m_we1), .m_wd(m_wd1), .m_dt(m_dt1),
        .m_rd(m_rd), .m_err(m_err)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3),
        .i_rdata(i_rdata3), .i_err(i_err3),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wd(d_wd), .d_dt(d_dt),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_err(d_err3),
        .m_en(m_en3), .m_addr(m_addr3), .m_we(m_we3), .m_wd(m_wd3), .m_dt(m_dt3),
        .m_rd(m_rd), .m_err(m_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wd = '0; d_dt = DT_W; m_err = ENONE;
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0000_5263;
        mem[2] = 32'h00a0_0093;
        for (int i = 3; i < 16; i++) mem[i] = 32'hdead_0000 + 32'(i);

        // Reset values.
        #2;
        chk("rst_i_gnt", {31'd0, i_gnt1}, 32'd0);
        chk("rst_m_en", {31'd0, m_en1}, 32'd0);
        chk("rst_m_we", {31'd0, m_we3}, 32'd0);
        chk("rst_m_addr", m_addr1, 32'd0);
        chk("rst_m_dt", 32'(m_dt1), 32'(DT_W));
        chk("rst_i_rdata", i_rdata1, 32'd0);
        chk("rst_d_err", 32'(d_err3), 32'(ENONE));

        // Single fetch at MEM_LAT=1.
        use3 = 1'b0;
        do_reset();
        i_req = 1'b1; i_addr = 32'h4;
        smp();
        chk("t1_gnt", {31'd0, i_gnt1}, 32'd1);
        chk("t1_m_en_n", {31'd0, m_en1}, 32'd0);
        nxt(); smp();
        chk("t1_m_en_n1", {31'd0, m_en1}, 32'd1);
        chk("t1_m_addr", m_addr1, 32'h4);
        chk("t1_gnt_off", {31'd0, i_gnt1}, 32'd0);
        chk("t1_rvalid_early", {31'd0, i_rvalid1}, 32'd0);
        nxt(); i_req = 1'b0; smp();
        chk("t1_rvalid", {31'd0, i_rvalid1}, 32'd1);
        chk("t1_rdata", i_rdata1, 32'h0000_5263);
        chk("t1_err", 32'(i_err1), 32'(ENONE));
        chk("t1_m_en_resp", {31'd0, m_en1}, 32'd0);

        // Tie after reset: fetch, data, fetch, data.
        do_reset();
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h8; d_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) nxt();
            if (k == 10) begin i_req = 1'b0; d_req = 1'b0; end
            smp();
            chk($sformatf("t2_i_gnt_%0d", k), {31'd0, i_gnt1}, {31'd0, k == 0 || k == 6});
            chk($sformatf("t2_d_gnt_%0d", k), {31'd0, d_gnt1}, {31'd0, k == 3 || k == 9});
            chk($sformatf("t2_i_rv_%0d", k), {31'd0, i_rvalid1}, {31'd0, k == 2 || k == 8});
            chk($sformatf("t2_d_rv_%0d", k), {31'd0, d_rvalid1}, {31'd0, k == 5 || k == 11});
            if (k == 5) chk("t2_d_rdata", d_rdata1, 32'h00a0_0093);
        end

        // MEM_LAT=3: load, then store, then erroring load, then fetch.
        use3 = 1'b1;
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        smp();
        chk("t3_ld_gnt", {31'd0, d_gnt3}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            nxt(); d_req = 1'b0; smp();
            chk($sformatf("t3_ld_m_en_%0d", c), {31'd0, m_en3}, 32'd1);
            chk($sformatf("t3_ld_m_we_%0d", c), {31'd0, m_we3}, 32'd0);
        end
        nxt(); smp();
        chk("t3_ld_rvalid", {31'd0, d_rvalid3}, 32'd1);
        chk("t3_ld_rdata", d_rdata3, 32'h00a0_0093);
        nxt();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wd = 32'hffff_ffff;
        smp();
        chk("t3_st_gnt", {31'd0, d_gnt3}, 32'd1);
        for (int c = 6; c <= 8; c++) begin
            nxt(); d_req = 1'b0; smp();
            chk($sformatf("t3_st_m_en_%0d", c), {31'd0, m_en3}, 32'd1);
            chk($sformatf("t3_st_m_we_%0d", c), {31'd0, m_we3}, {31'd0, c == 8});
            chk($sformatf("t3_st_m_wd_%0d", c), m_wd3, 32'hffff_ffff);
            chk($sformatf("t3_st_m_addr_%0d", c), m_addr3, 32'h40);
            chk($sformatf("t3_st_rv_%0d", c), {31'd0, d_rvalid3}, 32'd0);
        end
        nxt(); smp();
        chk("t3_st_rvalid", {31'd0, d_rvalid3}, 32'd1);
        chk("t3_st_rdata_kept", d_rdata3, 32'h00a0_0093);
        chk("t3_st_m_en_off", {31'd0, m_en3}, 32'd0);
        chk("t3_st_m_we_off", {31'd0, m_we3}, 32'd0);

        nxt();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; m_err = EALIGN;
        smp();
        chk("t4_gnt", {31'd0, d_gnt3}, 32'd1);
        for (int c = 11; c <= 13; c++) begin
            nxt(); d_req = 1'b0; m_err = (c == 13) ? EBUS : EALIGN; smp();
        end
        nxt(); m_err = ENONE; smp();
        chk("t4_rvalid", {31'd0, d_rvalid3}, 32'd1);
        chk("t4_d_err", 32'(d_err3), 32'(EBUS));
        chk("t4_d_rdata", d_rdata3, 32'h0000_5263);
        nxt(); i_req = 1'b1; i_addr = 32'h8; smp();
        chk("t4_f_gnt", {31'd0, i_gnt3}, 32'd1);
        for (int c = 16; c <= 18; c++) begin
            nxt(); i_req = 1'b0; smp();
        end
        nxt(); smp();
        chk("t4_f_rvalid", {31'd0, i_rvalid3}, 32'd1);
        chk("t4_f_err", 32'(i_err3), 32'(ENONE));
        chk("t4_f_rdata", i_rdata3, 32'h00a0_0093);
        chk("t4_d_err_hold", 32'(d_err3), 32'(EBUS));

        // Reset asserted in the second access cycle.
        do_reset();
        i_req = 1'b1; i_addr = 32'h0;
        smp();
        chk("t5_gnt", {31'd0, i_gnt3}, 32'd1);
        nxt(); smp();
        nxt(); d_req = 1'b1; d_addr = 32'h4; d_we = 1'b1; smp();
        chk("t5_m_en_acc2", {31'd0, m_en3}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_m_en_rst", {31'd0, m_en3}, 32'd0);
        chk("t5_m_we_rst", {31'd0, m_we3}, 32'd0);
        nxt(); smp();
        chk("t5_no_i_rv", {31'd0, i_rvalid3}, 32'd0);
        chk("t5_no_d_rv", {31'd0, d_rvalid3}, 32'd0);
        nxt(); rst = 1'b1; smp();
        chk("t5_regrant_i", {31'd0, i_gnt3}, 32'd1);
        chk("t5_regrant_d", {31'd0, d_gnt3}, 32'd0);

        // Back-to-back fetches at MEM_LAT=1.
        use3 = 1'b0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) nxt();
            i_req = 1'b1; i_addr = 32'(4 * (k / 3));
            smp();
            chk($sformatf("t6_gnt_%0d", k), {31'd0, i_gnt1}, {31'd0, (k % 3) == 0});
            chk($sformatf("t6_rv_%0d", k), {31'd0, i_rvalid1}, {31'd0, (k % 3) == 2});
            if ((k % 3) == 2) chk($sformatf("t6_rdata_%0d", k), i_rdata1, mem[k / 3]);
        end
        nxt(); i_req = 1'b0;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
